// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable prescaled down-counting timer with pause, abort, retrigger and auto-reload
module down_timer #(
  parameter int W  = 10,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  load_val,
  input  logic [PW-1:0] prescale,
  input  logic          auto_reload,
  input  logic          pause,
  input  logic          abort,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  q_n;
  logic [W-1:0]  lv, lv_n;
  logic [PW-1:0] pre, pre_n;
  logic [PW-1:0] pc, pc_n;
  logic          ar, ar_n;
  logic          done_n;
  logic          counting;

  // Leaving HOLD counts as an active cycle, so a pause of N cycles delays expiry by exactly N.
  assign counting = (state == RUN || state == HOLD) && !pause;

  // State, count, prescaler and latched start parameters; busy follows the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      pc    <= '0;
      lv    <= '0;
      pre   <= '0;
      ar    <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      pc    <= pc_n;
      lv    <= lv_n;
      pre   <= pre_n;
      ar    <= ar_n;
      done  <= done_n;
      busy  <= (state_n != IDLE);
    end
  end

  // Next-state logic in priority order: abort, start, pause, tick.
  always_comb begin
    state_n = state;
    q_n     = q;
    pc_n    = pc;
    lv_n    = lv;
    pre_n   = pre;
    ar_n    = ar;
    done_n  = 1'b0;

    if (abort) begin
      state_n = IDLE;
      q_n     = '0;
      pc_n    = '0;
    end else if (start) begin
      lv_n  = load_val;
      pre_n = prescale;
      ar_n  = auto_reload;
      pc_n  = '0;
      if (load_val != '0) begin
        q_n     = load_val;
        state_n = RUN;
      end else begin
        // Zero load expires at once and never reloads.
        q_n     = '0;
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end else if (state == RUN && pause) begin
      state_n = HOLD;
    end else if (counting) begin
      state_n = RUN;
      if (pc == pre) begin
        pc_n = '0;
        if (q > W'(1)) begin
          q_n = q - W'(1);
        end else begin
          done_n = 1'b1;
          if (ar) begin
            q_n = lv;
          end else begin
            q_n     = '0;
            state_n = IDLE;
          end
        end
      end else begin
        pc_n = pc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed self-checking bench for down_timer
module tb_down_timer;

  localparam int W  = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic          auto_reload;
  logic          pause;
  logic          abort;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  down_timer #(.W(W), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_val    (load_val),
    .prescale    (prescale),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .q           (q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int eq, input int eb, input int ed);
    check({tag, " q"}, int'(q), eq);
    check({tag, " busy"}, int'(busy), eb);
    check({tag, " done"}, int'(done), ed);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_val = '0; prescale = '0;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    step(); step();
    expect_out("reset", 0, 0, 0);
    rst = 1'b0;
    step();
    expect_out("idle", 0, 0, 0);

    // Basic count: load 3, prescale 0.
    start = 1'b1; load_val = 10'd3; prescale = 4'd0; auto_reload = 1'b0;
    step();
    start = 1'b0;
    expect_out("t1 e0", 3, 1, 0);
    step(); expect_out("t1 e1", 2, 1, 0);
    step(); expect_out("t1 e2", 1, 1, 0);
    step(); expect_out("t1 e3", 0, 0, 1);
    step(); expect_out("t1 e4", 0, 0, 0);

    // Prescaled count: load 2, prescale 3; inputs changed mid-run must be ignored.
    start = 1'b1; load_val = 10'd2; prescale = 4'd3;
    step();
    start = 1'b0; load_val = 10'd7; prescale = 4'd0;
    expect_out("t2 e0", 2, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_out($sformatf("t2 e%0d", k), (k < 4) ? 2 : (k < 8) ? 1 : 0,
                 (k < 8) ? 1 : 0, (k == 8) ? 1 : 0);
    end

    // Auto-reload: load 2, prescale 0.
    start = 1'b1; load_val = 10'd2; prescale = 4'd0; auto_reload = 1'b1;
    step();
    start = 1'b0; auto_reload = 1'b0;
    expect_out("t3 e0", 2, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      expect_out($sformatf("t3 e%0d", k), (k % 2 == 1) ? 1 : 2, 1, (k % 2 == 0) ? 1 : 0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("t3 abort", 0, 0, 0);
    step(); expect_out("t3 post", 0, 0, 0);

    // Pause for 3 cycles at q=4 with the prescaler mid-period.
    start = 1'b1; load_val = 10'd5; prescale = 4'd1;
    step();
    start = 1'b0;
    expect_out("t4 e0", 5, 1, 0);
    for (int k = 1; k <= 13; k++) begin
      int e;
      int eq;
      pause = (k >= 4 && k <= 6);
      step();
      e  = (k <= 3) ? k : (k <= 6) ? 2 : k - 3;
      eq = 5 - e / 2;
      expect_out($sformatf("t4 e%0d", k), eq, (k < 13) ? 1 : 0, (k == 13) ? 1 : 0);
    end
    pause = 1'b0;
    step(); expect_out("t4 post", 0, 0, 0);

    // Retrigger at q=2 of a load-6 run with load 4.
    start = 1'b1; load_val = 10'd6; prescale = 4'd0;
    step();
    start = 1'b0;
    expect_out("t5 e0", 6, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_out($sformatf("t5 e%0d", k), 6 - k, 1, 0);
    end
    start = 1'b1; load_val = 10'd4;
    step();
    start = 1'b0;
    expect_out("t5 retrig", 4, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_out($sformatf("t5 r%0d", k), 4 - k, (k < 4) ? 1 : 0, (k == 4) ? 1 : 0);
    end

    // Start and abort in the same cycle while running.
    start = 1'b1; load_val = 10'd5;
    step();
    expect_out("t5 run", 5, 1, 0);
    load_val = 10'd7; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    expect_out("t5 start+abort", 0, 0, 0);

    // Zero load with auto-reload: immediate expiry, stays idle.
    start = 1'b1; load_val = 10'd0; auto_reload = 1'b1;
    step();
    start = 1'b0; auto_reload = 1'b0;
    expect_out("t6 zero", 0, 0, 1);
    step(); expect_out("t6 zero post", 0, 0, 0);
    pause = 1'b1;
    step(); expect_out("t6 idle pause", 0, 0, 0);
    pause = 1'b0;

    // Reset mid-count.
    start = 1'b1; load_val = 10'd3; prescale = 4'd0;
    step();
    start = 1'b0;
    step();
    expect_out("t6 run", 2, 1, 0);
    rst = 1'b1;
    step(); expect_out("t6 rst", 0, 0, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out($sformatf("t6 after rst %0d", k), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
